// File: rtl/img_sram_port.sv
// Sequencing front-end for one image SRAM bank: single/burst read and write requests,
// raster address auto-increment with row wrap, and a 2-entry capture FIFO for sram_dout.
module img_sram_port #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 8,
  parameter int COL_W  = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ROW_W-1:0]  i_req_row,
  input  logic [COL_W-1:0]  i_req_col,
  input  logic [LEN_W-1:0]  i_req_len,
  input  logic              i_wdata_valid,
  output logic              o_wdata_ready,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_rdata_valid,
  input  logic              i_rdata_ready,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic              o_sram_write_en,
  output logic              o_sram_sense_en,
  output logic [ROW_W-1:0]  o_sram_row,
  output logic [COL_W-1:0]  o_sram_col,
  output logic [DATA_W-1:0] o_sram_din,
  input  logic [DATA_W-1:0] i_sram_dout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  logic [1:0]        r_state;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [LEN_W-1:0]  r_rem;
  logic              r_we;
  logic              r_se;
  logic [ROW_W-1:0]  r_srow;
  logic [COL_W-1:0]  r_scol;
  logic [DATA_W-1:0] r_din;
  logic              r_infl;
  logic [DATA_W-1:0] r_fifo [0:1];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_cnt;

  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_slots;
  logic              w_issue;
  logic              w_wbeat;
  logic              w_step;
  logic              w_last;
  logic [ROW_W-1:0]  w_row_nxt;
  logic [COL_W-1:0]  w_col_nxt;

  assign w_pop   = (r_cnt != 2'd0) & i_rdata_ready;
  assign w_push  = r_infl;
  // A read may only issue if its datum is sure to find a FIFO slot next cycle.
  assign w_slots = {1'b0, r_cnt} + {2'b00, r_infl} - {2'b00, w_pop};
  assign w_issue = (r_state == S_RD) & (w_slots < 3'd2);
  assign w_wbeat = (r_state == S_WR) & i_wdata_valid;
  assign w_step  = w_issue | w_wbeat;
  assign w_last  = (r_rem == {LEN_W{1'b0}});

  // Raster advance: column wraps into the next row, last row wraps to row 0.
  always_comb begin
    w_col_nxt = r_col + COL_W'(1);
    if (r_col == {COL_W{1'b1}}) begin
      w_row_nxt = r_row + ROW_W'(1);
    end else begin
      w_row_nxt = r_row;
    end
  end

  // Request FSM and burst address/length tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_row   <= {ROW_W{1'b0}};
      r_col   <= {COL_W{1'b0}};
      r_rem   <= {LEN_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_state <= i_req_write ? S_WR : S_RD;
            r_row   <= i_req_row;
            r_col   <= i_req_col;
            r_rem   <= i_req_len;
          end
        end
        S_WR, S_RD: begin
          if (w_step) begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_rem <= r_rem - LEN_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Macro command registers; idle cycles drive hold (we=0, se=1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_se   <= 1'b1;
      r_srow <= {ROW_W{1'b0}};
      r_scol <= {COL_W{1'b0}};
      r_din  <= {DATA_W{1'b0}};
      r_infl <= 1'b0;
    end else begin
      r_we   <= w_wbeat;
      r_se   <= ~w_issue;
      r_infl <= w_issue;
      if (w_step) begin
        r_srow <= r_row;
        r_scol <= r_col;
      end
      if (w_wbeat) begin
        r_din <= i_wdata;
      end
    end
  end

  // Two-entry output FIFO fed by the posedge following each read cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo[0] <= {DATA_W{1'b0}};
      r_fifo[1] <= {DATA_W{1'b0}};
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= i_sram_dout;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_req_ready     = (r_state == S_IDLE);
  assign o_wdata_ready   = (r_state == S_WR);
  assign o_rdata_valid   = (r_cnt != 2'd0);
  assign o_rdata         = r_fifo[r_rptr];
  assign o_busy          = (r_state != S_IDLE) | (r_cnt != 2'd0) | r_infl;
  assign o_sram_write_en = r_we;
  assign o_sram_sense_en = r_se;
  assign o_sram_row      = r_srow;
  assign o_sram_col      = r_scol;
  assign o_sram_din      = r_din;

endmodule
